multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Main control FSM for the multicycle MIPS-subset datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives every mux select (including AluSrcA), write enable and ALU opcode. Memory latency is modelled by a wait counter, and illegal opcodes and arithmetic overflow are trapped into sticky halt states.

Parameters:
MEM_WAIT, 2, cycles each memory read/write access is held (min 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; forces state RESET
Opcode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag (same cycle)
Overflow  in  1  ALU overflow flag (same cycle)
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if Zero
IorD  out  1  memory address: 0 PC, 1 ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
RegDst  out  1  0 rt, 1 rd
MemToReg  out  1  0 ALUOut, 1 MDR
AluSrcA  out  2  0 PC, 1 B, 2 A, 3 MemData
AluSrcB  out  2  0 B, 1 const 4, 2 signext imm, 3 signext imm<<2
AluOp  out  3  001 ADD, 010 SUB, 011 AND, 000 pass A
PCSource  out  2  0 ALU result, 1 ALUOut, 2 jump target
Illegal  out  1  sticky: unsupported opcode/funct
Exception  out  1  sticky: overflow trap
State  out  5  current state encoding, debug

Behaviour:
- All outputs are Moore, decoded from the state register, except PCWriteCond gating (PCWriteCond=1 only in BEQ; the datapath ANDs it with Zero).
- Reset: synchronous. When reset=1 at an edge, the next state is RESET and the wait counter is 0. Every control output is 0 in RESET, including Illegal, Exception, AluSrcA=0 and AluOp=000. RESET -> FETCH unconditionally. Reset mid-instruction aborts it; no partial write is issued after the reset edge.
- Wait counter: loaded to 0 on entry to any memory state. It increments each cycle while in the state. The state exits when count==MEM_WAIT-1.
- FETCH (MEM_WAIT cycles): MemRead=1, IorD=0, AluSrcA=0, AluSrcB=1, AluOp=ADD, PCSource=0. IRWrite=1 and PCWrite=1 only on the final cycle. Then -> DECODE.
- DECODE (1 cycle): AluSrcA=0, AluSrcB=3, AluOp=ADD (branch target into ALUOut).
  - Opcode 0x00 with Funct 0x20/0x22/0x24 -> R_EXEC.
  - 0x08 -> ADDI_EXEC.
  - 0x23 or 0x2B -> ADDR.
  - 0x04 -> BEQ.
  - 0x02 -> JUMP.
  - Anything else -> ILLEGAL.
- R_EXEC: AluSrcA=2, AluSrcB=0, AluOp = ADD/SUB/AND per Funct. If Overflow=1 and Funct is add/sub -> EXC, otherwise -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0. Then -> FETCH.
- ADDI_EXEC: AluSrcA=2, AluSrcB=2, AluOp=ADD. Overflow -> EXC, otherwise -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0. Then -> FETCH.
- ADDR: AluSrcA=2, AluSrcB=2, AluOp=ADD. Opcode 0x23 -> LW_READ, 0x2B -> SW_WRITE. No overflow trap on address calculation.
- LW_READ (MEM_WAIT cycles): MemRead=1, IorD=1. Then -> LW_WB.
- LW_WB: RegWrite=1, RegDst=0, MemToReg=1. Then -> FETCH.
- SW_WRITE (MEM_WAIT cycles): MemWrite=1, IorD=1. Then -> FETCH.
- BEQ: AluSrcA=2, AluSrcB=0, AluOp=SUB, PCWriteCond=1, PCSource=1. Then -> FETCH.
- JUMP: PCWrite=1, PCSource=2. Then -> FETCH.
- ILLEGAL: Illegal=1, all write enables 0. Stays in ILLEGAL until reset.
- EXC: Exception=1, all write enables 0, no RegWrite of the overflowed result. Stays in EXC until reset.
- Invalid state encodings -> RESET on the next edge.
- Latency with MEM_WAIT=2: R/addi 5 cycles, lw 7, sw 6, beq 4, j 4.
- No two write enables from different stages are ever asserted in the same cycle, except PCWrite+IRWrite in the last FETCH cycle.

Test Plan:
- Reset held for 3 cycles mid-LW_READ -> every output is 0 the cycle after the edge; next cycle FETCH with MemRead=1, AluSrcA=0, AluSrcB=1.
- Opcode 0x00, Funct 0x20, Overflow=0 -> sequence FETCH,FETCH,DECODE,R_EXEC,R_WB. RegWrite=1/RegDst=1 exactly once, at cycle 5; AluSrcA=2 in R_EXEC.
- Opcode 0x23 with MEM_WAIT=2, then 0x2B -> lw takes 7 cycles, with MemRead and IorD=1 for 2 cycles and MemToReg=1 in WB; sw takes 6 cycles with MemWrite=1 for exactly 2 cycles.
- Opcode 0x04 with Zero=1, then 0x02 -> BEQ: PCWriteCond=1, PCSource=1, AluOp=SUB. JUMP: PCWrite=1, PCSource=2. Both return to FETCH after 4 cycles.
- Opcode 0x08 with Overflow=1 in ADDI_EXEC -> EXC, Exception=1, RegWrite never asserted; stays in EXC for 20 cycles until reset.
- Opcode 0x3F, or 0x00 with Funct 0x25 -> ILLEGAL after DECODE, Illegal=1, no further MemRead; cleared only by reset.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// master = control unit, slave = datapath.
interface multicycle_control_unit_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       Overflow;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic [1:0] AluSrcA;
    logic [1:0] AluSrcB;
    logic [2:0] AluOp;
    logic [1:0] PCSource;
    logic       Illegal;
    logic       Exception;
    logic [4:0] State;

    modport master (
        input  Opcode, Funct, Zero, Overflow,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemToReg, AluSrcA, AluSrcB, AluOp,
               PCSource, Illegal, Exception, State
    );

    modport slave (
        output Opcode, Funct, Zero, Overflow,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemToReg, AluSrcA, AluSrcB, AluOp,
               PCSource, Illegal, Exception, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS-subset datapath; all outputs are
// Moore-decoded from the state register and the memory wait counter.
module multicycle_control_unit #(
    parameter int MEM_WAIT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_unit_if.master   bus
);
    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    localparam logic [4:0] S_RESET     = 5'd0;
    localparam logic [4:0] S_FETCH     = 5'd1;
    localparam logic [4:0] S_DECODE    = 5'd2;
    localparam logic [4:0] S_R_EXEC    = 5'd3;
    localparam logic [4:0] S_R_WB      = 5'd4;
    localparam logic [4:0] S_ADDI_EXEC = 5'd5;
    localparam logic [4:0] S_ADDI_WB   = 5'd6;
    localparam logic [4:0] S_ADDR      = 5'd7;
    localparam logic [4:0] S_LW_READ   = 5'd8;
    localparam logic [4:0] S_LW_WB     = 5'd9;
    localparam logic [4:0] S_SW_WRITE  = 5'd10;
    localparam logic [4:0] S_BEQ       = 5'd11;
    localparam logic [4:0] S_JUMP      = 5'd12;
    localparam logic [4:0] S_ILLEGAL   = 5'd13;
    localparam logic [4:0] S_EXC       = 5'd14;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    logic [4:0]    r_state;
    logic [CW-1:0] r_wait;
    logic [4:0]    w_next_state;
    logic          w_wait_done;
    logic          w_is_mem;
    logic          w_r_legal;
    logic          w_r_traps;
    logic [2:0]    w_r_aluop;

    assign w_wait_done = (r_wait == CW'(MEM_WAIT - 1));
    assign w_is_mem    = (r_state == S_FETCH) || (r_state == S_LW_READ) ||
                         (r_state == S_SW_WRITE);
    assign w_r_legal   = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB) ||
                         (bus.Funct == FN_AND);
    assign w_r_traps   = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB);

    always_comb begin
        case (bus.Funct)
            FN_SUB:  w_r_aluop = OP_SUB;
            FN_AND:  w_r_aluop = OP_AND;
            default: w_r_aluop = OP_ADD;
        endcase
    end

    always_comb begin
        w_next_state = S_RESET;
        case (r_state)
            S_RESET:     w_next_state = S_FETCH;
            S_FETCH:     w_next_state = w_wait_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    OPC_RTYPE:      w_next_state = w_r_legal ? S_R_EXEC : S_ILLEGAL;
                    OPC_ADDI:       w_next_state = S_ADDI_EXEC;
                    OPC_LW, OPC_SW: w_next_state = S_ADDR;
                    OPC_BEQ:        w_next_state = S_BEQ;
                    OPC_J:          w_next_state = S_JUMP;
                    default:        w_next_state = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:    w_next_state = (bus.Overflow && w_r_traps) ? S_EXC : S_R_WB;
            S_R_WB:      w_next_state = S_FETCH;
            S_ADDI_EXEC: w_next_state = bus.Overflow ? S_EXC : S_ADDI_WB;
            S_ADDI_WB:   w_next_state = S_FETCH;
            // Opcode is still lw or sw here; anything else only via a corrupted IR.
            S_ADDR:      w_next_state = (bus.Opcode == OPC_LW) ? S_LW_READ :
                                        (bus.Opcode == OPC_SW) ? S_SW_WRITE : S_ILLEGAL;
            S_LW_READ:   w_next_state = w_wait_done ? S_LW_WB : S_LW_READ;
            S_LW_WB:     w_next_state = S_FETCH;
            S_SW_WRITE:  w_next_state = w_wait_done ? S_FETCH : S_SW_WRITE;
            S_BEQ:       w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
            S_ILLEGAL:   w_next_state = S_ILLEGAL;
            S_EXC:       w_next_state = S_EXC;
            default:     w_next_state = S_RESET;
        endcase
    end

    // Counter restarts whenever the state changes, so each memory state starts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
            r_wait  <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || !w_is_mem)
                r_wait <= '0;
            else
                r_wait <= r_wait + CW'(1);
        end
    end

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.AluSrcA     = 2'd0;
        bus.AluSrcB     = 2'd0;
        bus.AluOp       = OP_PASS;
        bus.PCSource    = 2'd0;
        bus.Illegal     = 1'b0;
        bus.Exception   = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.AluSrcB = 2'd1;
                bus.AluOp   = OP_ADD;
                bus.IRWrite = w_wait_done;
                bus.PCWrite = w_wait_done;
            end
            S_DECODE: begin
                bus.AluSrcB = 2'd3;
                bus.AluOp   = OP_ADD;
            end
            S_R_EXEC: begin
                bus.AluSrcA = 2'd2;
                bus.AluOp   = w_r_aluop;
            end
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_ADDI_EXEC, S_ADDR: begin
                bus.AluSrcA = 2'd2;
                bus.AluSrcB = 2'd2;
                bus.AluOp   = OP_ADD;
            end
            S_ADDI_WB: bus.RegWrite = 1'b1;
            S_LW_READ: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_LW_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b1;
            end
            S_SW_WRITE: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_BEQ: begin
                bus.AluSrcA     = 2'd2;
                bus.AluOp       = OP_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'd1;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'd2;
            end
            S_ILLEGAL: bus.Illegal   = 1'b1;
            S_EXC:     bus.Exception = 1'b1;
            default: ;
        endcase
    end

    assign bus.State = r_state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded
// into its expected per-cycle control trace and compared cycle by cycle.
module tb_multicycle_control_unit;
    localparam int MW   = 2;
    localparam int HOLD = 20;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw, rdst, m2r;
        logic [1:0] srca, srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       ill, exc;
    } ctl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    ctl_t exp_q[$];

    multicycle_control_unit_if bus();

    multicycle_control_unit #(.MEM_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t c;
        c.pcw = bus.PCWrite;   c.pcwc = bus.PCWriteCond; c.iord = bus.IorD;
        c.mrd = bus.MemRead;   c.mwr = bus.MemWrite;     c.irw = bus.IRWrite;
        c.rw = bus.RegWrite;   c.rdst = bus.RegDst;      c.m2r = bus.MemToReg;
        c.srca = bus.AluSrcA;  c.srcb = bus.AluSrcB;     c.aluop = bus.AluOp;
        c.pcsrc = bus.PCSource; c.ill = bus.Illegal;     c.exc = bus.Exception;
        return c;
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
               op == 6'h23 || op == 6'h2B;
    endfunction

    // Expected control trace of one instruction, from first FETCH cycle on.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
        ctl_t c;
        exp_q.delete();
        for (int i = 0; i < MW; i++) begin
            c = '0; c.mrd = 1; c.srcb = 1; c.aluop = 3'b001;
            if (i == MW - 1) begin c.irw = 1; c.pcw = 1; end
            exp_q.push_back(c);
        end
        c = '0; c.srcb = 3; c.aluop = 3'b001; exp_q.push_back(c);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            c = '0; c.srca = 2;
            c.aluop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            exp_q.push_back(c);
            if (ovf && fn != 6'h24) begin
                c = '0; c.exc = 1;
                for (int i = 0; i < HOLD; i++) exp_q.push_back(c);
            end else begin
                c = '0; c.rw = 1; c.rdst = 1; exp_q.push_back(c);
            end
        end else if (op == 6'h08) begin
            c = '0; c.srca = 2; c.srcb = 2; c.aluop = 3'b001; exp_q.push_back(c);
            if (ovf) begin
                c = '0; c.exc = 1;
                for (int i = 0; i < HOLD; i++) exp_q.push_back(c);
            end else begin
                c = '0; c.rw = 1; exp_q.push_back(c);
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.srca = 2; c.srcb = 2; c.aluop = 3'b001; exp_q.push_back(c);
            for (int i = 0; i < MW; i++) begin
                c = '0; c.iord = 1;
                if (op == 6'h23) c.mrd = 1; else c.mwr = 1;
                exp_q.push_back(c);
            end
            if (op == 6'h23) begin
                c = '0; c.rw = 1; c.m2r = 1; exp_q.push_back(c);
            end
        end else if (op == 6'h04) begin
            c = '0; c.srca = 2; c.aluop = 3'b010; c.pcwc = 1; c.pcsrc = 1;
            exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c = '0; c.pcw = 1; c.pcsrc = 2; exp_q.push_back(c);
        end else begin
            c = '0; c.ill = 1;
            for (int i = 0; i < HOLD; i++) exp_q.push_back(c);
        end
    endtask

    // Entered at the negedge showing the first FETCH cycle; leaves at the
    // negedge following the last checked cycle.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic zero, input int limit);
        build(op, fn, ovf);
        bus.Opcode = op; bus.Funct = fn; bus.Overflow = ovf; bus.Zero = zero;
        for (int i = 0; i < exp_q.size() && i < limit; i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(obs()), 32'(exp_q[i]));
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("reset[%0d]", i), 32'(obs()), 32'(ctl_t'('0)));
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] op, fn;
        logic       ovf;
        int         kind;
        bus.Opcode = '0; bus.Funct = '0; bus.Overflow = 1'b0; bus.Zero = 1'b0;
        @(negedge clk);
        do_reset(3);

        run_instr("add", 6'h00, 6'h20, 1'b0, 1'b0, 1000);
        run_instr("lw", 6'h23, 6'h00, 1'b0, 1'b0, 1000);
        run_instr("sw", 6'h2B, 6'h11, 1'b1, 1'b0, 1000);
        run_instr("beq", 6'h04, 6'h00, 1'b0, 1'b1, 1000);
        run_instr("j", 6'h02, 6'h3F, 1'b1, 1'b1, 1000);
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 1'b0, MW + 3);
        do_reset(3);
        run_instr("addi_ovf", 6'h08, 6'h00, 1'b1, 1'b0, 1000);
        do_reset(1);
        run_instr("ill_op", 6'h3F, 6'h20, 1'b0, 1'b0, 1000);
        do_reset(1);
        run_instr("ill_fn", 6'h00, 6'h25, 1'b0, 1'b0, 1000);
        do_reset(1);
        run_instr("and_ovf", 6'h00, 6'h24, 1'b1, 1'b0, 1000);
        run_instr("sub_ovf", 6'h00, 6'h22, 1'b1, 1'b0, 1000);
        do_reset(2);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 19);
            ovf  = ($urandom_range(0, 3) == 0);
            fn   = 6'($urandom);
            case (kind)
                0, 1, 2, 3: begin
                    op = 6'h00;
                    case ($urandom_range(0, 2))
                        0: fn = 6'h20;
                        1: fn = 6'h22;
                        default: fn = 6'h24;
                    endcase
                end
                4, 5:        op = 6'h08;
                6, 7, 8:     op = 6'h23;
                9, 10, 11:   op = 6'h2B;
                12, 13, 14:  op = 6'h04;
                15, 16, 17:  op = 6'h02;
                18: begin
                    op = 6'($urandom);
                    while (legal_op(op)) op = 6'($urandom);
                end
                default: begin
                    op = 6'h00;
                    while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) fn = 6'($urandom);
                end
            endcase
            run_instr($sformatf("rnd%0d_op%02h", n, op), op, fn, ovf, 1'($urandom), 1000);
            if (bus.Illegal === 1'b1 || bus.Exception === 1'b1)
                do_reset(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
